// File: rtl/jt6295_phrase_fetch.sv
// Per-voice OKI6295 phrase sequencer: reads the 6-byte phrase header, then streams
// sample bytes through a two-byte buffer and presents them as high-then-low nibbles.
module jt6295_phrase_fetch #(
    parameter logic [17:0] HDR_BASE = 18'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [6:0]  phrase,
    output logic        rom_cs,
    output logic [17:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok,
    output logic [3:0]  nib,
    output logic        nib_valid,
    input  logic        nib_req,
    output logic        busy,
    output logic        done,
    output logic        bad
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_CHK, S_DATA, S_END} state_t;

    state_t      state_q, state_d;
    logic        rom_cs_q, rom_cs_d;
    logic [17:0] rom_addr_q, rom_addr_d;
    logic        skip_q, skip_d;
    logic [2:0]  hcnt_q, hcnt_d;
    logic [17:0] start_q, start_d;
    logic [17:0] end_q, end_d;
    logic [7:0]  obuf_q, obuf_d;
    logic [7:0]  pbuf_q, pbuf_d;
    logic        ovalid_q, ovalid_d;
    logic        pvalid_q, pvalid_d;
    logic        lo_q, lo_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bad_q, bad_d;
    logic [3:0]  nib_q, nib_d;

    logic capture;
    logic consume;

    assign capture = rom_cs_q & rom_ok & ~skip_q;
    assign consume = nib_req & ovalid_q;

    always_comb begin
        state_d    = state_q;
        rom_cs_d   = rom_cs_q;
        rom_addr_d = rom_addr_q;
        hcnt_d     = hcnt_q;
        start_d    = start_q;
        end_d      = end_q;
        obuf_d     = obuf_q;
        pbuf_d     = pbuf_q;
        ovalid_d   = ovalid_q;
        pvalid_d   = pvalid_q;
        lo_d       = lo_q;
        last_d     = last_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bad_d      = bad_q;

        case (state_q)
            S_IDLE: begin
                if (start && !stop && phrase != 7'd0) begin
                    state_d    = S_HDR;
                    busy_d     = 1'b1;
                    bad_d      = 1'b0;
                    rom_cs_d   = 1'b1;
                    rom_addr_d = HDR_BASE + {8'd0, phrase, 3'd0};
                    hcnt_d     = 3'd0;
                end
            end
            S_HDR: begin
                if (capture) begin
                    case (hcnt_q)
                        3'd0:    start_d[17:16] = rom_data[1:0];
                        3'd1:    start_d[15:8]  = rom_data;
                        3'd2:    start_d[7:0]   = rom_data;
                        3'd3:    end_d[17:16]   = rom_data[1:0];
                        3'd4:    end_d[15:8]    = rom_data;
                        default: end_d[7:0]     = rom_data;
                    endcase
                    if (hcnt_q == 3'd5) begin
                        rom_cs_d = 1'b0;
                        state_d  = S_CHK;
                    end else begin
                        rom_addr_d = rom_addr_q + 18'd1;
                        hcnt_d     = hcnt_q + 3'd1;
                    end
                end
            end
            S_CHK: begin
                if (end_q < start_q) begin
                    bad_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_DATA;
                    rom_addr_d = start_q;
                    rom_cs_d   = 1'b1;
                    last_d     = 1'b0;
                    ovalid_d   = 1'b0;
                    pvalid_d   = 1'b0;
                    lo_d       = 1'b0;
                end
            end
            S_DATA: begin
                // Consumption is resolved first so a same-cycle capture lands in the freed slot.
                if (consume) begin
                    if (lo_q) begin
                        ovalid_d = pvalid_q;
                        obuf_d   = pbuf_q;
                        pvalid_d = 1'b0;
                        lo_d     = 1'b0;
                    end else begin
                        lo_d = 1'b1;
                    end
                end
                if (capture) begin
                    if (!ovalid_d) begin
                        obuf_d   = rom_data;
                        ovalid_d = 1'b1;
                    end else begin
                        pbuf_d   = rom_data;
                        pvalid_d = 1'b1;
                    end
                    if (rom_addr_q == end_q) last_d = 1'b1;
                    else                     rom_addr_d = rom_addr_q + 18'd1;
                end
                rom_cs_d = ~last_d & ~(ovalid_d & pvalid_d);
                if (last_d && !ovalid_d) begin
                    state_d = S_END;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (stop && (state_q == S_HDR || state_q == S_CHK || state_q == S_DATA)) begin
            state_d    = S_IDLE;
            rom_cs_d   = 1'b0;
            rom_addr_d = rom_addr_q;
            ovalid_d   = 1'b0;
            pvalid_d   = 1'b0;
            lo_d       = 1'b0;
            last_d     = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            bad_d      = bad_q;
        end

        nib_d  = ovalid_d ? (lo_d ? obuf_d[3:0] : obuf_d[7:4]) : 4'd0;
        // A new address or a fresh select makes the arbiter's current ok stale for one cycle.
        skip_d = rom_cs_d & (~rom_cs_q | (rom_addr_d != rom_addr_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            skip_q     <= 1'b0;
            hcnt_q     <= '0;
            start_q    <= '0;
            end_q      <= '0;
            obuf_q     <= '0;
            pbuf_q     <= '0;
            ovalid_q   <= 1'b0;
            pvalid_q   <= 1'b0;
            lo_q       <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bad_q      <= 1'b0;
            nib_q      <= '0;
        end else begin
            state_q    <= state_d;
            rom_cs_q   <= rom_cs_d;
            rom_addr_q <= rom_addr_d;
            skip_q     <= skip_d;
            hcnt_q     <= hcnt_d;
            start_q    <= start_d;
            end_q      <= end_d;
            obuf_q     <= obuf_d;
            pbuf_q     <= pbuf_d;
            ovalid_q   <= ovalid_d;
            pvalid_q   <= pvalid_d;
            lo_q       <= lo_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bad_q      <= bad_d;
            nib_q      <= nib_d;
        end
    end

    assign rom_cs    = rom_cs_q;
    assign rom_addr  = rom_addr_q;
    assign nib       = nib_q;
    assign nib_valid = ovalid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bad       = bad_q;

endmodule

// File: tb/tb_jt6295_phrase_fetch.sv
// Scoreboard bench for jt6295_phrase_fetch: stimulus queues expected nibbles and done
// events; a negedge monitor pops and compares them as the DUT presents them.
module tb_jt6295_phrase_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop;
    logic [6:0]  phrase;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic [3:0]  nib;
    logic        nib_valid;
    logic        nib_req;
    logic        busy, done, bad;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:16383];
    logic [17:0] a1, a2;
    logic        c1, c2;
    logic        stale_mode = 1'b0;
    int          req_div = 1;
    int          cyc = 0;

    logic [3:0]  exp_nib [$];
    logic        exp_done [$];
    logic [17:0] addr_log [$];
    logic        prev_cs = 1'b0;
    logic [17:0] prev_addr = '0;
    logic        seen_valid = 1'b0;
    int          done_cnt = 0;
    logic [3:0]  en;
    logic        eb;

    jt6295_phrase_fetch #(.HDR_BASE(18'h0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .phrase(phrase),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .nib(nib), .nib_valid(nib_valid), .nib_req(nib_req),
        .busy(busy), .done(done), .bad(bad)
    );

    always #5 clk = ~clk;

    // Arbiter model: two-cycle latency normally; in stale mode ok stays high and data lags one cycle.
    always @(posedge clk) begin
        a1 <= rom_addr; a2 <= a1;
        c1 <= rom_cs;   c2 <= c1;
    end

    always @* begin
        if (stale_mode) begin
            rom_data = mem[a1[13:0]];
            rom_ok   = rom_cs;
        end else begin
            rom_data = mem[a2[13:0]];
            rom_ok   = rom_cs && c1 && c2 && (a1 == rom_addr) && (a2 == rom_addr);
        end
    end

    initial begin
        nib_req = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            nib_req = (req_div == 0) ? 1'b0 : ((cyc % req_div) == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (nib_valid && nib_req) begin
                if (exp_nib.size() == 0) chk("unexpected_nib", 1, 0);
                else begin
                    en = exp_nib.pop_front();
                    chk("nib", {28'd0, nib}, {28'd0, en});
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    eb = exp_done.pop_front();
                    chk("done_bad", {31'd0, bad}, {31'd0, eb});
                end
            end
            if (nib_valid) seen_valid = 1'b1;
            if (rom_cs && (!prev_cs || rom_addr != prev_addr)) addr_log.push_back(rom_addr);
            prev_cs   = rom_cs;
            prev_addr = rom_addr;
        end
    end

    task automatic set_hdr(input int n, input logic [7:0] b0, b1, b2, b3, b4, b5);
        mem[n*8+0] = b0; mem[n*8+1] = b1; mem[n*8+2] = b2;
        mem[n*8+3] = b3; mem[n*8+4] = b4; mem[n*8+5] = b5;
    endtask

    task automatic go(input logic [6:0] p, input logic with_stop);
        @(negedge clk);
        phrase = p; start = 1'b1; stop = with_stop;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        logic got;
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) chk({name, "_timeout"}, 0, 1);
        @(negedge clk);
        chk({name, "_busy_low"}, {31'd0, busy}, 0);
        chk({name, "_nibs_left"}, exp_nib.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; phrase = '0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {13'd0, rom_cs, rom_addr}, 0);
        chk("reset_flags", {25'd0, nib, nib_valid, busy, done, bad}, 0);
        rst_n = 1'b1;

        // Phrase 1: start 0x100, end 0x101.
        set_hdr(1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01);
        mem[14'h100] = 8'hA5; mem[14'h101] = 8'h3C;
        req_div = 1;
        addr_log.delete();
        exp_nib = '{4'hA, 4'h5, 4'h3, 4'hC};
        exp_done.push_back(1'b0);
        go(7'd1, 1'b0);
        chk("p1_busy", {31'd0, busy}, 1);
        wait_done("p1", 300);
        chk("p1_issues", addr_log.size(), 8);

        // Single-byte phrase at 0x2000.
        set_hdr(3, 8'hFC, 8'h20, 8'h00, 8'hFC, 8'h20, 8'h00);
        mem[14'h2000] = 8'h7E;
        addr_log.delete();
        exp_nib = '{4'h7, 4'hE};
        exp_done.push_back(1'b0);
        go(7'd3, 1'b0);
        wait_done("p3", 300);
        chk("p3_issues", addr_log.size(), 7);
        chk("p3_cs_low", {31'd0, rom_cs}, 0);

        // Slow consumer forces the prefetch slot full.
        set_hdr(4, 8'h00, 8'h03, 8'h00, 8'h00, 8'h03, 8'h02);
        mem[14'h300] = 8'h12; mem[14'h301] = 8'h34; mem[14'h302] = 8'h56;
        req_div = 5;
        exp_nib = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        exp_done.push_back(1'b0);
        go(7'd4, 1'b0);
        wait_done("p4", 400);
        req_div = 1;

        // Bad header: end < start.
        set_hdr(5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'hFF);
        addr_log.delete();
        seen_valid = 1'b0;
        exp_done.push_back(1'b1);
        go(7'd5, 1'b0);
        wait_done("p5", 300);
        chk("p5_bad", {31'd0, bad}, 1);
        chk("p5_issues", addr_log.size(), 6);
        chk("p5_no_valid", {31'd0, seen_valid}, 0);

        // Stale ok across address changes; also clears bad on accept.
        set_hdr(6, 8'h00, 8'h04, 8'h00, 8'h00, 8'h04, 8'h01);
        mem[14'h400] = 8'h9D; mem[14'h401] = 8'hE2;
        stale_mode = 1'b1;
        exp_nib = '{4'h9, 4'hD, 4'hE, 4'h2};
        exp_done.push_back(1'b0);
        go(7'd6, 1'b0);
        chk("p6_bad_cleared", {31'd0, bad}, 0);
        wait_done("p6", 300);
        stale_mode = 1'b0;

        // Stop in the very cycle the first data byte would be captured.
        set_hdr(7, 8'h00, 8'h05, 8'h00, 8'h00, 8'h05, 8'h0F);
        mem[14'h500] = 8'h88;
        go(7'd7, 1'b0);
        begin
            logic hit;
            hit = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(negedge clk);
                if (rom_cs && rom_addr == 18'h500) hit = 1'b1;
            end
            chk("p7_data_addr_seen", {31'd0, hit}, 1);
        end
        @(negedge clk);
        @(negedge clk);
        chk("p7_ok_pending", {31'd0, rom_ok}, 1);
        exp_done.push_back(1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("p7_stop_state", {28'd0, rom_cs, nib_valid, busy, done}, 32'h1);

        // Phrase 2 header lives at 0x10..0x15.
        set_hdr(2, 8'h00, 8'h06, 8'h00, 8'h00, 8'h06, 8'h00);
        mem[14'h600] = 8'h4B;
        addr_log.delete();
        exp_nib = '{4'h4, 4'hB};
        exp_done.push_back(1'b0);
        go(7'd2, 1'b0);
        wait_done("p2", 300);
        chk("p2_issues", addr_log.size(), 7);
        for (int i = 0; i < 6; i++)
            if (i < addr_log.size()) chk("p2_hdr_addr", {14'd0, addr_log[i]}, 32'h10 + i);
        if (addr_log.size() > 6) chk("p2_data_addr", {14'd0, addr_log[6]}, 32'h600);

        // Ignored commands.
        addr_log.delete();
        begin
            int d0;
            d0 = done_cnt;
            go(7'd0, 1'b0);
            go(7'd1, 1'b1);
            repeat (10) @(negedge clk);
            chk("ign_issues", addr_log.size(), 0);
            chk("ign_busy", {31'd0, busy}, 0);
            chk("ign_done", done_cnt - d0, 0);
        end

        // Asynchronous reset in the middle of DATA with nothing consumed.
        req_div = 0;
        go(7'd1, 1'b0);
        begin
            logic hit;
            hit = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(negedge clk);
                if (nib_valid) hit = 1'b1;
            end
            chk("rst_reach_data", {31'd0, hit}, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bus", {13'd0, rom_cs, rom_addr}, 0);
        chk("async_rst_flags", {25'd0, nib, nib_valid, busy, done, bad}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", {30'd0, busy, rom_cs}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
